// File: rtl/addsub_seq_pkg.sv
// Shared definitions for the nibble-serial add/subtract unit.
package addsub_seq_pkg;

  localparam int unsigned NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/addsub_slice4.sv
// 4-bit add/subtract slice with carry-in, carry-out and carry into the MSB.
module addsub_slice4
  import addsub_seq_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b,
  input  logic                sub,
  input  logic                ci,
  output logic [NIBBLE_W-1:0] s,
  output logic                co,
  output logic                c_msb
);

  localparam int unsigned M = NIBBLE_W - 1;

  logic [NIBBLE_W-1:0] bx;
  logic [NIBBLE_W-1:0] low;

  assign bx = b ^ {NIBBLE_W{sub}};

  // Split at the MSB so the carry into it is visible for overflow detection.
  assign low        = {1'b0, a[M-1:0]} + {1'b0, bx[M-1:0]} + {{M{1'b0}}, ci};
  assign c_msb      = low[M];
  assign s[M-1:0]   = low[M-1:0];
  assign {co, s[M]} = {1'b0, a[M]} + {1'b0, bx[M]} + {1'b0, c_msb};

endmodule

// File: rtl/addsub_seq.sv
// Nibble-serial add/subtract with valid/ready handshake; one 4-bit slice reused per cycle.
// Optional overflow output enabled by defining ADDSUB_SEQ_OVF_EN.
module addsub_seq
  import addsub_seq_pkg::*;
#(
  parameter int unsigned NIBBLES = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [NIBBLE_W*NIBBLES-1:0]  A,
  input  logic [NIBBLE_W*NIBBLES-1:0]  B,
  input  logic                         subtract,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [NIBBLE_W*NIBBLES-1:0]  sum,
  output logic                         cout,
  output logic                         zero,
  output logic                         busy
`ifdef ADDSUB_SEQ_OVF_EN
  ,
  output logic                         ovf
`endif
);

  localparam int unsigned W     = NIBBLE_W * NIBBLES;
  localparam int unsigned IDX_W = $clog2(NIBBLES + 1);

  state_t             state, state_nxt;
  logic [IDX_W-1:0]   idx, idx_nxt;
  logic               carry, carry_nxt;
  logic [W-1:0]       a_q, a_nxt;
  logic [W-1:0]       b_q, b_nxt;
  logic               sub_q, sub_nxt;
  logic [W-1:0]       sum_nxt;
  logic               cout_nxt, zero_nxt;
  logic               in_ready_nxt, out_valid_nxt, busy_nxt;
  logic               last;

  logic [NIBBLE_W-1:0] a_nib, b_nib, s_s;
  logic                s_co, s_cmsb;

`ifdef ADDSUB_SEQ_OVF_EN
  logic ovf_nxt;
`else
  logic cmsb_unused;
  assign cmsb_unused = s_cmsb;
`endif

  assign last = (idx == IDX_W'(NIBBLES - 1));

  // Select the operand nibbles addressed by idx.
  always_comb begin
    a_nib = '0;
    b_nib = '0;
    for (int i = 0; i < int'(NIBBLES); i++) begin
      if (idx == IDX_W'(i)) begin
        a_nib = a_q[i*NIBBLE_W +: NIBBLE_W];
        b_nib = b_q[i*NIBBLE_W +: NIBBLE_W];
      end
    end
  end

  addsub_slice4 u_slice (
    .a     (a_nib),
    .b     (b_nib),
    .sub   (sub_q),
    .ci    (carry),
    .s     (s_s),
    .co    (s_co),
    .c_msb (s_cmsb)
  );

  // Next-state and next-output logic.
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    carry_nxt = carry;
    a_nxt     = a_q;
    b_nxt     = b_q;
    sub_nxt   = sub_q;
    sum_nxt   = sum;
    cout_nxt  = cout;
    zero_nxt  = zero;
`ifdef ADDSUB_SEQ_OVF_EN
    ovf_nxt   = ovf;
`endif
    case (state)
      IDLE: begin
        if (in_valid) begin
          a_nxt     = A;
          b_nxt     = B;
          sub_nxt   = subtract;
          idx_nxt   = '0;
          carry_nxt = subtract;
          cout_nxt  = 1'b0;
          zero_nxt  = 1'b0;
`ifdef ADDSUB_SEQ_OVF_EN
          ovf_nxt   = 1'b0;
`endif
          state_nxt = RUN;
        end
      end
      RUN: begin
        for (int i = 0; i < int'(NIBBLES); i++) begin
          if (idx == IDX_W'(i)) sum_nxt[i*NIBBLE_W +: NIBBLE_W] = s_s;
        end
        carry_nxt = s_co;
        idx_nxt   = idx + IDX_W'(1);
        if (last) begin
          cout_nxt  = s_co;
          zero_nxt  = (sum_nxt == '0);
`ifdef ADDSUB_SEQ_OVF_EN
          ovf_nxt   = s_cmsb ^ s_co;
`endif
          state_nxt = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    in_ready_nxt  = (state_nxt == IDLE);
    out_valid_nxt = (state_nxt == DONE);
    busy_nxt      = (state_nxt != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      idx       <= '0;
      carry     <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      sub_q     <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
      zero      <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
`ifdef ADDSUB_SEQ_OVF_EN
      ovf       <= 1'b0;
`endif
    end else begin
      state     <= state_nxt;
      idx       <= idx_nxt;
      carry     <= carry_nxt;
      a_q       <= a_nxt;
      b_q       <= b_nxt;
      sub_q     <= sub_nxt;
      sum       <= sum_nxt;
      cout      <= cout_nxt;
      zero      <= zero_nxt;
      in_ready  <= in_ready_nxt;
      out_valid <= out_valid_nxt;
      busy      <= busy_nxt;
`ifdef ADDSUB_SEQ_OVF_EN
      ovf       <= ovf_nxt;
`endif
    end
  end

endmodule
